// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
//   Sequences one calculator operation: captures operand A, then operand B,
//   launches the multi-cycle arithmetic unit with a start/done handshake and
//   latches its result. The result can be chained in as the next operand A.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_enter, i_clear          one-cycle button pulses (clear wins over all)
//   i_value [W], i_op [2]     keyed operand and op select (add/sub/mul/div)
//   i_alu_done/result/err/sign  arithmetic unit completion, valid with done
//   o_alu_start               one-cycle launch pulse
//   o_s1, o_s2, o_op          operands and op code presented to the unit
//   o_result, o_sign, o_err   latched outcome
//   o_disp_sel [2]            00 entry A, 01 entry B, 10 busy/err, 11 result
//   o_led [10]                [0] A, [1] B, [2] busy, [3] result, [4] err, [9] blink
//
// state  | meaning
// GET_A  | waiting for operand A
// GET_B  | waiting for operand B and op code
// LAUNCH | single cycle, start pulse to the arithmetic unit
// BUSY   | waiting for done, bounded by TIMEOUT cycles
// SHOW   | result displayed, enter chains it into operand A
// ERR    | arithmetic error or timeout, only clear leaves
module calc_op_sequencer #(
    parameter int W         = 40,
    parameter int TIMEOUT   = 1023,
    parameter int BLINK_DIV = 24
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_enter,
    input  logic         i_clear,
    input  logic [W-1:0] i_value,
    input  logic [1:0]   i_op,
    input  logic         i_alu_done,
    input  logic [W-1:0] i_alu_result,
    input  logic         i_alu_err,
    input  logic         i_alu_sign,
    output logic         o_alu_start,
    output logic [W-1:0] o_s1,
    output logic [W-1:0] o_s2,
    output logic [1:0]   o_op,
    output logic [W-1:0] o_result,
    output logic         o_sign,
    output logic         o_err,
    output logic [1:0]   o_disp_sel,
    output logic [9:0]   o_led
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] TO_MAX  = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        LAUNCH = 3'd2,
        BUSY   = 3'd3,
        SHOW   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     s1_q, s1_d;
    logic [W-1:0]     s2_q, s2_d;
    logic [1:0]       op_q, op_d;
    logic [W-1:0]     result_q, result_d;
    logic             sign_q, sign_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [BLINK_DIV:0] blink_q, blink_d;

    // BUSY gives up once TIMEOUT cycles have elapsed without done
    logic timed_out;
    assign timed_out = (wait_q >= TO_LAST);

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = GET_A;
        end else begin
            case (state_q)
                GET_A:   if (i_enter) state_d = GET_B;
                GET_B:   if (i_enter) state_d = LAUNCH;
                LAUNCH:  state_d = BUSY;
                BUSY: begin
                    if (i_alu_done)     state_d = i_alu_err ? ERR : SHOW;
                    else if (timed_out) state_d = ERR;
                end
                SHOW:    if (i_enter) state_d = GET_B;
                ERR:     state_d = ERR;
                default: state_d = GET_A;
            endcase
        end
    end

    // datapath next values
    always_comb begin
        s1_d     = s1_q;
        s2_d     = s2_q;
        op_d     = op_q;
        result_d = result_q;
        sign_d   = sign_q;
        err_d    = err_q;
        start_d  = 1'b0;
        wait_d   = wait_q;
        blink_d  = blink_q + 1'b1;
        if (i_clear) begin
            s1_d     = '0;
            s2_d     = '0;
            op_d     = '0;
            result_d = '0;
            sign_d   = 1'b0;
            err_d    = 1'b0;
            wait_d   = '0;
            blink_d  = '0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (i_enter) s1_d = i_value;
                end
                GET_B: begin
                    if (i_enter) begin
                        s2_d    = i_value;
                        op_d    = i_op;
                        // registered so the pulse coincides with state LAUNCH
                        start_d = 1'b1;
                    end
                end
                LAUNCH: begin
                    wait_d = '0;
                end
                BUSY: begin
                    if (i_alu_done) begin
                        result_d = i_alu_result;
                        sign_d   = i_alu_sign;
                        err_d    = i_alu_err;
                    end else begin
                        if (wait_q != TO_MAX) wait_d = wait_q + 1'b1;
                        if (timed_out)        err_d  = 1'b1;
                    end
                end
                SHOW: begin
                    // chained operand keeps its sign in o_sign until next launch
                    if (i_enter) s1_d = result_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            op_q     <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            wait_q   <= '0;
            blink_q  <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            op_q     <= op_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            err_q    <= err_d;
            start_q  <= start_d;
            wait_q   <= wait_d;
            blink_q  <= blink_d;
        end
    end

    // state-decoded outputs
    always_comb begin
        o_disp_sel = 2'b00;
        o_led      = 10'b0;
        case (state_q)
            GET_A: begin
                o_disp_sel = 2'b00;
                o_led[0]   = 1'b1;
            end
            GET_B: begin
                o_disp_sel = 2'b01;
                o_led[1]   = 1'b1;
            end
            LAUNCH, BUSY: begin
                o_disp_sel = 2'b10;
                o_led[2]   = 1'b1;
            end
            SHOW: begin
                o_disp_sel = 2'b11;
                o_led[3]   = 1'b1;
            end
            ERR: begin
                o_disp_sel = 2'b10;
                o_led[4]   = 1'b1;
            end
            default: ;
        endcase
        if (state_q == BUSY || state_q == ERR) o_led[9] = blink_q[BLINK_DIV];
    end

    assign o_alu_start = start_q;
    assign o_s1        = s1_q;
    assign o_s2        = s2_q;
    assign o_op        = op_q;
    assign o_result    = result_q;
    assign o_sign      = sign_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;

    localparam int W = 40;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_enter, i_clear;
    logic [W-1:0] i_value;
    logic [1:0]   i_op;
    logic         i_alu_done;
    logic [W-1:0] i_alu_result;
    logic         i_alu_err, i_alu_sign;
    logic         o_alu_start;
    logic [W-1:0] o_s1, o_s2, o_result;
    logic [1:0]   o_op, o_disp_sel;
    logic         o_sign, o_err;
    logic [9:0]   o_led;

    calc_op_sequencer #(.W(W), .TIMEOUT(8), .BLINK_DIV(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enter(i_enter), .i_clear(i_clear),
        .i_value(i_value), .i_op(i_op), .i_alu_done(i_alu_done),
        .i_alu_result(i_alu_result), .i_alu_err(i_alu_err), .i_alu_sign(i_alu_sign),
        .o_alu_start(o_alu_start), .o_s1(o_s1), .o_s2(o_s2), .o_op(o_op),
        .o_result(o_result), .o_sign(o_sign), .o_err(o_err),
        .o_disp_sel(o_disp_sel), .o_led(o_led)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        logic         sign;
        logic [1:0]   disp;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    always @(negedge i_clk) if (o_alu_start === 1'b1) start_cnt++;

    function automatic logic [W-1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return (b == 0) ? '0 : a / b;
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic press_enter(input logic [W-1:0] v, input logic [1:0] op);
        i_value = v;
        i_op    = op;
        i_enter = 1'b1;
        tick();
        i_enter = 1'b0;
    endtask

    task automatic alu_respond(input int dly, input logic [W-1:0] res, input logic err,
                               input logic sign);
        repeat (dly) tick();
        i_alu_done   = 1'b1;
        i_alu_result = res;
        i_alu_err    = err;
        i_alu_sign   = sign;
        tick();
        i_alu_done   = 1'b0;
        i_alu_err    = 1'b0;
        i_alu_sign   = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_enter = 0; i_clear = 0; i_value = '0; i_op = 0;
        i_alu_done = 0; i_alu_result = '0; i_alu_err = 0; i_alu_sign = 0;
        repeat (2) tick();
        checks++; if (o_disp_sel !== 2'b00) begin errors++; $display("FAIL reset_disp got=%b exp=00", o_disp_sel); end
        checks++; if (o_led !== 10'h001) begin errors++; $display("FAIL reset_led got=%h exp=001", o_led); end
        checks++; if (o_alu_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", o_alu_start); end
        checks++; if (o_result !== '0) begin errors++; $display("FAIL reset_result got=%0d exp=0", o_result); end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        int s0;
        exp_t e;
        press_enter(25, 2'b00);
        checks++; if (o_disp_sel !== 2'b01 || o_led !== 10'h002) begin errors++; $display("FAIL add_getb got=%b/%h exp=01/002", o_disp_sel, o_led); end
        s0 = start_cnt;
        press_enter(17, 2'b00);
        sb.push_back('{calc(25, 17, 2'b00), 1'b0, 1'b0, 2'b11});
        checks++; if (o_alu_start !== 1'b1) begin errors++; $display("FAIL add_start got=%b exp=1", o_alu_start); end
        checks++; if (o_s1 !== 25 || o_s2 !== 17 || o_op !== 2'b00) begin errors++; $display("FAIL add_operands got=%0d,%0d,%b exp=25,17,00", o_s1, o_s2, o_op); end
        alu_respond(3, calc(25, 17, 2'b00), 1'b0, 1'b0);
        e = sb.pop_front();
        checks++; if (o_result !== e.res || o_disp_sel !== e.disp) begin errors++; $display("FAIL add_result got=%0d/%b exp=%0d/%b", o_result, o_disp_sel, e.res, e.disp); end
        checks++; if (o_led !== 10'h008 || o_err !== e.err) begin errors++; $display("FAIL add_led got=%h/%b exp=008/%b", o_led, o_err, e.err); end
        repeat (3) tick();
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL add_start_count got=%0d exp=1", start_cnt - s0); end
    endtask

    task automatic test_chain_mul();
        exp_t e;
        press_enter(99, 2'b00);
        checks++; if (o_s1 !== 42 || o_disp_sel !== 2'b01) begin errors++; $display("FAIL chain_s1 got=%0d/%b exp=42/01", o_s1, o_disp_sel); end
        press_enter(2, 2'b10);
        sb.push_back('{calc(42, 2, 2'b10), 1'b0, 1'b1, 2'b11});
        checks++; if (o_s1 !== 42 || o_s2 !== 2 || o_op !== 2'b10 || o_alu_start !== 1'b1) begin errors++; $display("FAIL chain_launch got=%0d,%0d,%b,%b exp=42,2,10,1", o_s1, o_s2, o_op, o_alu_start); end
        alu_respond(2, calc(42, 2, 2'b10), 1'b0, 1'b1);
        e = sb.pop_front();
        checks++; if (o_result !== e.res || o_sign !== e.sign || o_disp_sel !== e.disp) begin errors++; $display("FAIL chain_result got=%0d/%b/%b exp=%0d/%b/%b", o_result, o_sign, o_disp_sel, e.res, e.sign, e.disp); end
    endtask

    task automatic test_div_err();
        exp_t e;
        bit seen0, seen1;
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        press_enter(9, 2'b00);
        press_enter(0, 2'b11);
        sb.push_back('{calc(9, 0, 2'b11), 1'b1, 1'b0, 2'b10});
        alu_respond(2, calc(9, 0, 2'b11), 1'b1, 1'b0);
        e = sb.pop_front();
        checks++; if (o_err !== e.err || o_disp_sel !== e.disp || o_led[4] !== 1'b1 || o_result !== e.res) begin errors++; $display("FAIL div_err got=%b/%b/%b/%0d exp=%b/%b/1/%0d", o_err, o_disp_sel, o_led[4], o_result, e.err, e.disp, e.res); end
        press_enter(5, 2'b00);
        checks++; if (o_led[8:0] !== 9'h010 || o_s1 !== 9) begin errors++; $display("FAIL err_enter_ignored got=%h/%0d exp=010/9", o_led[8:0], o_s1); end
        seen0 = 0; seen1 = 0;
        for (int i = 0; i < 16; i++) begin
            if (o_led[9] === 1'b1) seen1 = 1;
            if (o_led[9] === 1'b0) seen0 = 1;
            tick();
        end
        checks++; if (!(seen0 && seen1)) begin errors++; $display("FAIL err_blink got=seen0:%0d seen1:%0d exp=1,1", seen0, seen1); end
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        checks++; if (o_led !== 10'h001 || o_err !== 1'b0 || o_disp_sel !== 2'b00) begin errors++; $display("FAIL err_clear got=%h/%b/%b exp=001/0/00", o_led, o_err, o_disp_sel); end
    endtask

    task automatic test_timeout();
        exp_t e;
        press_enter(7, 2'b00);
        press_enter(3, 2'b00);
        sb.push_back('{'0, 1'b1, 1'b0, 2'b10});
        repeat (8) tick();
        checks++; if (o_led[2] !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL timeout_early got=busy:%b err:%b exp=1/0", o_led[2], o_err); end
        tick();
        e = sb.pop_front();
        checks++; if (o_err !== e.err || o_disp_sel !== e.disp || o_led[4] !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b/%b/%b exp=%b/%b/1", o_err, o_disp_sel, o_led[4], e.err, e.disp); end
        alu_respond(0, 55, 1'b0, 1'b0);
        checks++; if (o_result !== e.res || o_led[4] !== 1'b1) begin errors++; $display("FAIL timeout_late_done got=%0d/%b exp=%0d/1", o_result, o_led[4], e.res); end
        i_clear = 1'b1; tick(); i_clear = 1'b0;
    endtask

    task automatic test_clear_priority();
        press_enter(5, 2'b00);
        press_enter(6, 2'b00);
        tick();
        i_clear = 1'b1; i_alu_done = 1'b1; i_alu_result = 11;
        tick();
        i_clear = 1'b0; i_alu_done = 1'b0;
        checks++; if (o_led !== 10'h001 || o_result !== '0 || o_s1 !== '0) begin errors++; $display("FAIL clear_done got=%h/%0d/%0d exp=001/0/0", o_led, o_result, o_s1); end
        alu_respond(0, 77, 1'b0, 1'b0);
        checks++; if (o_result !== '0 || o_disp_sel !== 2'b00) begin errors++; $display("FAIL late_done got=%0d/%b exp=0/00", o_result, o_disp_sel); end
        i_clear = 1'b1;
        press_enter(33, 2'b00);
        i_clear = 1'b0;
        checks++; if (o_disp_sel !== 2'b00 || o_s1 !== '0) begin errors++; $display("FAIL clear_enter got=%b/%0d exp=00/0", o_disp_sel, o_s1); end
    endtask

    task automatic test_async_reset_busy();
        int s0;
        press_enter(5, 2'b00);
        press_enter(6, 2'b00);
        tick();
        i_rst_n = 1'b0;
        #2;
        checks++; if (o_disp_sel !== 2'b00 || o_alu_start !== 1'b0 || o_s1 !== '0) begin errors++; $display("FAIL async_rst got=%b/%b/%0d exp=00/0/0", o_disp_sel, o_alu_start, o_s1); end
        tick();
        i_rst_n = 1'b1;
        s0 = start_cnt;
        repeat (5) tick();
        checks++; if (start_cnt - s0 !== 0 || o_led !== 10'h001) begin errors++; $display("FAIL async_no_restart got=%0d/%h exp=0/001", start_cnt - s0, o_led); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_chain_mul();
        test_div_err();
        test_timeout();
        test_clear_priority();
        test_async_reset_busy();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
